// File: rtl/spine_ingress_route_stage_if.sv
// Flit bus of one spine ingress stage: upstream flits in, routing-table lookup,
// and the routed flit stream towards the crossbar.
interface spine_ingress_route_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [5:0]        rt_dest_addr;
    logic [3:0]        rt_out_port;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [3:0]        out_port;

    // The ingress stage itself.
    modport slave (
        input  in_valid, in_data, in_last, rt_out_port, out_ready,
        output in_ready, rt_dest_addr, out_valid, out_data, out_last, out_port
    );

    // Upstream source, routing table and crossbar as seen from outside.
    modport master (
        output in_valid, in_data, in_last, rt_out_port, out_ready,
        input  in_ready, rt_dest_addr, out_valid, out_data, out_last, out_port
    );
endinterface

// File: rtl/spine_ingress_route_stage.sv
// Spine switch ingress: buffers flits, looks up the head flit's destination in
// the routing table, then forwards the whole packet on the locked port or drops it.
module spine_ingress_route_stage #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spine_ingress_route_stage_if.slave   bus,
    output logic                         route_err,
    output logic [CNT_W-1:0]             pkt_cnt,
    output logic [CNT_W-1:0]             drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ROUTE, FWD, DROP} state_t;

    state_t            state;
    logic [DATA_W:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   head;
    logic [DATA_W:0]   hold;
    logic [5:0]        dest_q;
    logic [3:0]        port_q;
    logic              fwd_valid;

    assign empty        = (count == '0);
    assign head         = mem[rd_ptr];
    assign bus.in_ready = rst_n && (count < FULL_CNT);
    assign push         = bus.in_valid && bus.in_ready;
    assign fwd_valid    = (state == FWD) && !empty;
    assign pop          = (fwd_valid && bus.out_ready) || ((state == DROP) && !empty);

    // During an underrun bubble the last forwarded flit stays on the bus.
    assign bus.out_valid    = fwd_valid;
    assign bus.out_data     = fwd_valid ? head[DATA_W-1:0] : hold[DATA_W-1:0];
    assign bus.out_last     = fwd_valid ? head[DATA_W]     : hold[DATA_W];
    assign bus.out_port     = port_q;
    assign bus.rt_dest_addr = dest_q;
    assign route_err        = (state == ROUTE) && (bus.rt_out_port == 4'd0);

    // NOTE: storage has no reset; validity is tracked by count, so a flush only
    // needs the pointers cleared and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dest_q   <= '0;
            port_q   <= '0;
            hold     <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        dest_q <= head[5:0];
                        state  <= ROUTE;
                    end
                end
                ROUTE: begin
                    port_q <= bus.rt_out_port;
                    state  <= (bus.rt_out_port == 4'd0) ? DROP : FWD;
                end
                FWD: begin
                    if (pop) begin
                        hold <= head;
                        if (head[DATA_W]) begin
                            if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (pop && head[DATA_W]) begin
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spine_ingress_route_stage.sv
// Self-checking bench for spine_ingress_route_stage: a scoreboard of expected
// forwarded flits is filled as packets are sent and drained by an output monitor.
module tb_spine_ingress_route_stage;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [3:0]        port;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             route_err;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] drop_cnt;

    spine_ingress_route_stage_if #(.DATA_W(DATA_W)) bus ();

    spine_ingress_route_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .route_err (route_err),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Spine routing table: group 0 is unreachable, everything else maps to a port.
    function automatic logic [3:0] rt_lookup(input logic [5:0] a);
        case (a)
            6'b010000: return 4'd1;
            6'b010001: return 4'd2;
            6'b010010: return 4'd3;
            6'b010011: return 4'd4;
            6'b000101: return 4'd5;
            6'b100000: return 4'd11;
            default:   return (a[5:2] == 4'd0) ? 4'd0 : 4'((int'(a) % 15) + 1);
        endcase
    endfunction

    assign bus.rt_out_port = rt_lookup(bus.rt_dest_addr);

    function automatic logic [DATA_W-1:0] mk_data(input int id, input int idx, input logic [5:0] a);
        return {id[15:0], 10'(idx), a};
    endfunction

    exp_t sb[$];
    exp_t mon_e;
    int   fire_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_pkt = 0;
    int   exp_drop = 0;
    int   err_seen = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    logic              prev_hold = 1'b0;
    logic              prev_err = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [3:0]        prev_port;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_port !== prev_port) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h port=%h, required valid=1 data=%h port=%h",
                             bus.out_valid, bus.out_data, bus.out_port, prev_data, prev_port);
                end
            end
            if (route_err === 1'b1) begin
                err_seen++;
                checks++;
                if (prev_err || bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL route_err_pulse: prev_err=%b out_valid=%b, required prev_err=0 out_valid=0",
                             prev_err, bus.out_valid);
                end
            end
            prev_err = (route_err === 1'b1);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                fire_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flit: data=%h port=%h, required no output", bus.out_data, bus.out_port);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.out_data !== mon_e.data || bus.out_last !== mon_e.last || bus.out_port !== mon_e.port) begin
                        errors++;
                        $display("FAIL flit: data=%h last=%b port=%h, required data=%h last=%b port=%h",
                                 bus.out_data, bus.out_last, bus.out_port, mon_e.data, mon_e.last, mon_e.port);
                    end
                end
            end
            prev_hold = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_data = bus.out_data;
            prev_port = bus.out_port;
        end
    end

    // Caller is just after a rising edge; returns just after the accepting edge.
    task automatic send_flit(input logic [DATA_W-1:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: in_ready=%b, required 1 within 1000 cycles", bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [5:0] a, input int len, input int id);
        logic [3:0]        port;
        logic [DATA_W-1:0] d;
        exp_t              e;
        port = rt_lookup(a);
        for (int i = 0; i < len; i++) begin
            d = mk_data(id, i, a);
            if (port != 4'd0) begin
                e.data = d;
                e.last = (i == len - 1);
                e.port = port;
                sb.push_back(e);
            end
            send_flit(d, i == len - 1);
        end
        if (port != 4'd0) exp_pkt++;
        else exp_drop++;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(sb.size() == 0 && pkt_cnt == CNT_W'(exp_pkt) && drop_cnt == CNT_W'(exp_drop))) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL %s_drain_timeout: pending=%0d pkt_cnt=%0d drop_cnt=%0d, required 0/%0d/%0d",
                         name, sb.size(), pkt_cnt, drop_cnt, exp_pkt, exp_drop);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_data !== '0 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL reset_out_data: got %h/%b, required 0/0", bus.out_data, bus.out_last);
        end
        if (bus.out_port !== 4'd0 || bus.rt_dest_addr !== 6'd0) begin
            errors++; $display("FAIL reset_route: port=%h addr=%h, required 0/0", bus.out_port, bus.rt_dest_addr);
        end
        if (pkt_cnt !== '0 || drop_cnt !== '0) begin
            errors++; $display("FAIL reset_counters: pkt=%0d drop=%0d, required 0/0", pkt_cnt, drop_cnt);
        end
        if (route_err !== 1'b0) begin errors++; $display("FAIL reset_route_err: got %b, required 0", route_err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, required 1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_packet();
        exp_t e;
        bus.out_ready = 1'b1;
        e.data = mk_data(1, 0, 6'b010010);
        e.last = 1'b0;
        e.port = 4'b0011;
        sb.push_back(e);
        send_flit(e.data, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.rt_dest_addr !== 6'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle_cycle: addr=%b valid=%b, required 000000/0", bus.rt_dest_addr, bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.rt_dest_addr !== 6'b010010 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_route_cycle: addr=%b valid=%b, required 010010/0", bus.rt_dest_addr, bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_port !== 4'b0011) begin
            errors++; $display("FAIL single_first_valid: valid=%b port=%b, required 1/0011", bus.out_valid, bus.out_port);
        end
        @(posedge clk);
        #1;
        for (int i = 1; i < 3; i++) begin
            e.data = mk_data(1, i, 6'b010010);
            e.last = (i == 2);
            sb.push_back(e);
            send_flit(e.data, e.last);
        end
        exp_pkt++;
        wait_done("single");
        checks += 2;
        if (pkt_cnt !== CNT_W'(1)) begin errors++; $display("FAIL single_pkt_cnt: got %0d, required 1", pkt_cnt); end
        if (bus.out_port !== 4'b0011 || bus.rt_dest_addr !== 6'b010010) begin
            errors++; $display("FAIL single_retain: port=%b addr=%b, required 0011/010010", bus.out_port, bus.rt_dest_addr);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d0;
        bus.out_ready = 1'b0;
        d0 = mk_data(2, 0, 6'b000101);
        send_pkt(6'b000101, 2, 2);
        send_pkt(6'b010010, 2, 3);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b, required 0", bus.in_ready); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_port !== 4'b0101 || bus.out_data !== d0) begin
                errors++;
                $display("FAIL bp_stall_%0d: valid=%b port=%b data=%h, required 1/0101/%h",
                         k, bus.out_valid, bus.out_port, bus.out_data, d0);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done("backpressure");
        checks++;
        if (pkt_cnt !== CNT_W'(exp_pkt)) begin errors++; $display("FAIL bp_pkt_cnt: got %0d, required %0d", pkt_cnt, exp_pkt); end
    endtask

    task automatic test_drop();
        int err_before;
        err_before = err_seen;
        bus.out_ready = 1'b1;
        exp_drop++;
        send_flit(mk_data(4, 0, 6'b000001), 1'b0);
        @(negedge clk);
        checks++;
        if (route_err !== 1'b0) begin errors++; $display("FAIL drop_err_early: got %b, required 0", route_err); end
        @(negedge clk);
        checks++;
        if (route_err !== 1'b1) begin errors++; $display("FAIL drop_err_in_route: got %b, required 1", route_err); end
        @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) send_flit(mk_data(4, i, 6'b000001), i == 3);
        send_pkt(6'b100000, 2, 5);
        wait_done("drop");
        checks += 3;
        if (err_seen - err_before != 1) begin errors++; $display("FAIL drop_err_count: got %0d, required 1", err_seen - err_before); end
        if (drop_cnt !== CNT_W'(1)) begin errors++; $display("FAIL drop_cnt: got %0d, required 1", drop_cnt); end
        if (bus.out_port !== 4'b1011) begin errors++; $display("FAIL drop_next_port: got %b, required 1011", bus.out_port); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        fire_cyc.delete();
        send_pkt(6'b010000, 1, 6);
        send_pkt(6'b010011, 1, 7);
        wait_done("back_to_back");
        checks++;
        if (fire_cyc.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d flits, required 2", fire_cyc.size());
        end else if (fire_cyc[1] - fire_cyc[0] != 3) begin
            errors++; $display("FAIL b2b_gap: got %0d cycles apart, required 3", fire_cyc[1] - fire_cyc[0]);
        end
    endtask

    task automatic test_random();
        logic rand_done = 1'b0;
        int   err_before;
        err_before = err_seen - exp_drop;
        fork
            begin
                logic [5:0] a;
                for (int k = 0; k < 50; k++) begin
                    if ($urandom_range(0, 5) == 0) a = {4'd0, 2'($urandom_range(0, 3))};
                    else a = {4'($urandom_range(1, 15)), 2'($urandom_range(0, 3))};
                    send_pkt(a, $urandom_range(1, 6), 100 + k);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_done("random");
        checks += 3;
        if (pkt_cnt !== CNT_W'(exp_pkt)) begin errors++; $display("FAIL rand_pkt_cnt: got %0d, required %0d", pkt_cnt, exp_pkt); end
        if (drop_cnt !== CNT_W'(exp_drop)) begin errors++; $display("FAIL rand_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop); end
        if (err_seen - err_before != exp_drop) begin
            errors++; $display("FAIL rand_err_count: got %0d, required %0d", err_seen - err_before, exp_drop);
        end
    endtask

    task automatic test_reset_mid_packet();
        bus.out_ready = 1'b0;
        send_flit(mk_data(8, 0, 6'b010010), 1'b0);
        send_flit(mk_data(8, 1, 6'b010010), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_handshake: in_ready=%b out_valid=%b, required 0/0", bus.in_ready, bus.out_valid);
        end
        if (pkt_cnt !== '0 || drop_cnt !== '0) begin
            errors++; $display("FAIL mid_reset_counters: pkt=%0d drop=%0d, required 0/0", pkt_cnt, drop_cnt);
        end
        if (bus.out_port !== 4'd0 || bus.rt_dest_addr !== 6'd0) begin
            errors++; $display("FAIL mid_reset_route: port=%b addr=%b, required 0/0", bus.out_port, bus.rt_dest_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        bus.out_ready = 1'b1;
        send_pkt(6'b000101, 2, 9);
        wait_done("reset_mid");
        checks += 2;
        if (pkt_cnt !== CNT_W'(1)) begin errors++; $display("FAIL mid_reset_pkt_cnt: got %0d, required 1", pkt_cnt); end
        if (bus.out_port !== 4'b0101) begin errors++; $display("FAIL mid_reset_port: got %b, required 0101", bus.out_port); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_random();
        test_reset_mid_packet();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
